// File: rtl/uart_tx_port.sv
// uart_tx_port: bus-mapped UART transmitter (FIFO + 8N1 serialiser); define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx_port #(
  parameter int BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hF0000030,
  parameter logic [BITS-1:0] CTRL_BASE = 32'hF0000130,
  parameter int CLK_PER_BIT = 217,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            tx,
  output logic            inta_ready
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int CNTW = FIFO_DEPTH_LOG2 + 1;
  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] TC = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_POST = S_PAR;
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic [2:0] S_POST = S_STOP;
  localparam logic PAR_EN = 1'b0;
`endif
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CNTW-1:0] count_q;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, par_q, ie_q, ovf_q, inta_q;
  logic wr_data, wr_ctrl, rd, full, push, pop, tc, busy, unused_bits;

  assign wr_data = we && memAddr == BASE;
  assign wr_ctrl = we && memAddr == CTRL_BASE;
  assign rd = re && !we;
  assign full = count_q == CNTW'(DEPTH);
  assign push = wr_data && !full;
  assign pop = state_q == S_IDLE && count_q != '0;
  assign tc = baud_q == TC;
  assign busy = state_q != S_IDLE || count_q != '0;
  assign unused_bits = ^dataBusIn[BITS-1:9];

  assign dataBusOut = (rd && memAddr == BASE) ? BITS'(count_q) :
                      (rd && memAddr == CTRL_BASE) ? BITS'({ie_q, 3'b000, PAR_EN, !busy, ovf_q, busy, !full}) : '0;
  assign tx = tx_q;
  assign inta_ready = inta_q;

  // Baud counter only runs while a frame is on the line; each slot advances on terminal count.
  assign baud_d = (state_q == S_IDLE || tc) ? '0 : baud_q + CW'(1);
  assign shift_d = pop ? mem_q[head_q] : (state_q == S_DATA && tc) ? shift_q >> 1 : shift_q;
  assign bit_d = pop ? '0 : (state_q == S_DATA && tc) ? bit_q + 3'd1 : bit_q;
  assign state_d = pop ? S_START :
                   (!tc || state_q == S_IDLE) ? state_q :
                   state_q == S_START ? S_DATA :
                   state_q == S_DATA ? (bit_q == 3'd7 ? S_POST : S_DATA) :
                   state_q == S_PAR ? S_STOP : S_IDLE;
  // tx is registered from the current state, so the line lags the FSM by one clock.
  assign tx_d = state_q == S_START ? 1'b0 :
                state_q == S_DATA ? shift_q[0] :
                state_q == S_PAR ? par_q : 1'b1;

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) par_q <= 1'b0;
    else if (pop) par_q <= ^mem_q[head_q];
`else
  assign par_q = 1'b0;
`endif

  always_ff @(posedge clk)
    if (push) mem_q[tail_q] <= dataBusIn[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      bit_q <= '0;
      baud_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ie_q <= 1'b0;
      ovf_q <= 1'b0;
      inta_q <= 1'b0;
    end else begin
      head_q <= head_q + AW'(pop);
      tail_q <= tail_q + AW'(push);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
      state_q <= state_d;
      bit_q <= bit_d;
      baud_q <= baud_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      inta_q <= ie_q && !busy;
      if (wr_ctrl) begin
        ie_q <= dataBusIn[8];
        if (!dataBusIn[2]) ovf_q <= 1'b0;
      end else if (wr_data && full) begin
        ovf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port; a line monitor decodes frames and checks them against queued bytes
module tb_uart_tx_port;
  localparam int CPB = 4;
  localparam logic [31:0] BASE = 32'hF0000030;
  localparam logic [31:0] CTRL = 32'hF0000130;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PARB = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] PARB = 32'h0;
`endif
  logic clk = 0, reset = 0, we = 0, re = 0;
  logic [31:0] memAddr = '0, dataBusIn = '0, dataBusOut, v;
  logic tx, inta_ready;
  int n_cmp = 0, n_err = 0, cyc = 0, bb_n = 0, last_f = 0;
  logic mon_en = 1, bb_on = 0;
  logic [7:0] sb [$];

  uart_tx_port #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .tx(tx), .inta_ready(inta_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1; memAddr = a; dataBusIn = d;
    @(posedge clk);
    #1 we = 0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    re = 1; memAddr = a;
    #1 chk(tag, dataBusOut, exp);
    re = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Line monitor: samples each bit slot near its middle.
  initial begin
    logic [7:0] d, e;
    logic b0, p, s;
    int f;
    forever begin
      @(negedge tx);
      @(negedge clk);
      f = cyc;
      @(negedge clk);
      b0 = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        d[i] = tx;
      end
      p = 1'b0;
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      p = tx;
`endif
      repeat (CPB) @(negedge clk);
      s = tx;
      if (mon_en) begin
        chk("start_bit", b0, 0);
        if (sb.size() == 0) chk("unexpected_frame", d, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("byte", d, e);
`ifdef UART_TX_PARITY_EN
          chk("parity", p, ^e);
`endif
        end
        chk("stop_bit", s, 1);
        if (bb_on) begin
          if (bb_n > 0) chk("frame_gap", f - last_f, NB * CPB + 1);
          bb_n++;
        end
      end
      last_f = f;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("rst_tx", tx, 1);
    chk("rst_inta", inta_ready, 0);
    chk("rst_bus", dataBusOut, 0);
    chk_rd("rst_ctrl", CTRL, 32'h9 | PARB);
    @(negedge clk) reset = 1;

    sb.push_back(8'hA5);
    wr(BASE, 32'h0000_00A5);
    chk("tx_e0", tx, 1);
    @(posedge clk) #1 chk("tx_e1", tx, 1);
    @(posedge clk) #1 chk("tx_e2", tx, 0);
    chk_rd("busy", CTRL, 32'h3 | PARB);
    drain();
    repeat (8) @(posedge clk);
    chk_rd("done", CTRL, 32'h9 | PARB);
    chk_rd("cnt_empty", BASE, 0);

    bb_on = 1; bb_n = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) sb.push_back(8'(i));
      wr(BASE, 32'hFFFF_FF00 | i);
    end
    chk_rd("cnt_full", BASE, 8);
    chk_rd("ovf", CTRL, 32'h6 | PARB);
    wr(CTRL, 32'h0000_0004);
    chk_rd("ovf_keep", CTRL, 32'h6 | PARB);
    wr(CTRL, 32'h0);
    chk_rd("ovf_clr", CTRL, 32'h2 | PARB);
    drain();
    bb_on = 0;
    chk("bb_frames", bb_n, 9);
    repeat (8) @(posedge clk);

    wr(CTRL, 32'h100);
    chk("irq_off", inta_ready, 0);
    @(posedge clk) #1 chk("irq_on", inta_ready, 1);
    chk_rd("ie_rd", CTRL, 32'h109 | PARB);
    sb.push_back(8'h55);
    wr(BASE, 32'h55);
    @(posedge clk) #1 chk("irq_push", inta_ready, 0);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        re = 1; memAddr = CTRL;
        #1 v = dataBusOut;
        re = 0;
        k++;
      end while (!v[3] && k < 300);
    end
    chk("done_seen", v[3], 1);
    chk("irq_lag", inta_ready, 0);
    @(posedge clk) #1 chk("irq_rise", inta_ready, 1);
    chk("sb_after_irq", sb.size(), 0);
    wr(CTRL, 32'h0);
    chk("irq_hold", inta_ready, 1);
    @(posedge clk) #1 chk("irq_clr", inta_ready, 0);

    chk_rd("dec_base", BASE + 4, 0);
    chk_rd("dec_ctrl", CTRL + 4, 0);
    @(negedge clk);
    we = 1; re = 1; memAddr = CTRL; dataBusIn = 32'h0;
    #1 chk("dec_we", dataBusOut, 0);
    @(posedge clk) #1 begin we = 0; re = 0; end

    mon_en = 0;
    for (int i = 0; i < 4; i++) wr(BASE, 32'hC0 + i);
    repeat (10) @(posedge clk);
    chk_rd("pre_rst_cnt", BASE, 3);
    @(negedge clk) reset = 0;
    #1 chk("rst_mid_tx", tx, 1);
    re = 1; memAddr = BASE;
    #1 chk("rst_mid_cnt", dataBusOut, 0);
    re = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    chk_rd("post_rst_ctrl", CTRL, 32'h9 | PARB);
    begin
      int lows = 0;
      repeat (30) begin
        @(negedge clk);
        if (!tx) lows++;
      end
      chk("post_rst_idle", lows, 0);
    end
    repeat (30) @(posedge clk);
    mon_en = 1;

    sb.push_back(8'h07);
    wr(BASE, 32'h07);
    drain();
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
